// File: rtl/merge_ctrl_if.sv
// Port bundle for merge_ctrl: run control, the two FIFO read sides and the merged output stream.
interface merge_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 16
);
    logic                  start;
    logic [CNT_W-1:0]      run_len;
    logic                  a_empty;
    logic [DATA_WIDTH-1:0] a_head;
    logic                  a_rd_en;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] b_head;
    logic                  b_rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, run_len, a_empty, a_head, b_empty, b_head, out_ready,
        output a_rd_en, b_rd_en, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, run_len, a_empty, a_head, b_empty, b_head, out_ready,
        input  a_rd_en, b_rd_en, out_data, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/merge_ctrl.sv
// Merge-step sequencer: pops the smaller of two sorted FIFO heads (ties to A) into a
// registered output stream until both runs of run_len words are consumed.
module merge_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    merge_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MERGE   = 3'd1,
        DRAIN_A = 3'd2,
        DRAIN_B = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]      cnt_b_q, cnt_b_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  done_q, done_d;

    logic adv;
    logic pop_a;
    logic pop_b;
    logic a_final;
    logic b_final;

    always_comb begin
        state_d     = state_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        pop_a       = 1'b0;
        pop_b       = 1'b0;
        adv         = !out_valid_q || bus.out_ready;
        a_final     = (cnt_a_q == CNT_W'(1));
        b_final     = (cnt_b_q == CNT_W'(1));

        case (state_q)
            IDLE: begin
                // done_q high means a run just finished; a start in that cycle is dropped
                if (bus.start && !done_q) begin
                    if (bus.run_len != '0) begin
                        cnt_a_d = bus.run_len;
                        cnt_b_d = bus.run_len;
                        state_d = MERGE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            MERGE: begin
                if (adv && !bus.a_empty && !bus.b_empty) begin
                    if (bus.a_head <= bus.b_head) pop_a = 1'b1;
                    else                          pop_b = 1'b1;
                end
            end
            DRAIN_A: pop_a = adv && !bus.a_empty && (cnt_a_q != '0);
            DRAIN_B: pop_b = adv && !bus.b_empty && (cnt_b_q != '0);
            FLUSH: begin
                if (out_valid_q && bus.out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_a) begin
            out_data_d  = bus.a_head;
            out_valid_d = 1'b1;
            out_last_d  = (state_q == DRAIN_A) && a_final;
            cnt_a_d     = cnt_a_q - CNT_W'(1);
            if (a_final) state_d = (state_q == MERGE) ? DRAIN_B : FLUSH;
        end else if (pop_b) begin
            out_data_d  = bus.b_head;
            out_valid_d = 1'b1;
            out_last_d  = (state_q == DRAIN_B) && b_final;
            cnt_b_d     = cnt_b_q - CNT_W'(1);
            if (b_final) state_d = (state_q == MERGE) ? DRAIN_A : FLUSH;
        end else if (adv) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    // Pops are suppressed while reset is held so an aborted merge never consumes a word
    assign bus.a_rd_en   = pop_a && !reset;
    assign bus.b_rd_en   = pop_b && !reset;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule
